vga_frame_grab: RTL and testbench
=================================

VGA_FRAME_GRAB -- requirements
Module: vga_frame_grab

Interface
REQ-001 The block SHALL have parameter WIN_W, default 100, meaning capture window width in pixels.
REQ-002 The block SHALL have parameter WIN_H, default 100, meaning capture window height in lines.
REQ-003 The block SHALL have parameter X0, default 0, meaning window left edge in active-pixel coordinates.
REQ-004 The block SHALL have parameter Y0, default 0, meaning window top edge in active-line coordinates.
REQ-005 The block SHALL have port VGA_CLK  in  1  pixel clock (25 MHz); all logic on its rising edge.
REQ-006 The block SHALL have port reset  in  1  reset, synchronous, active-high; clock VGA_CLK.
REQ-007 The block SHALL have port iVGA_R/iVGA_G/iVGA_B  in  8 each  incoming colour; 0 when blanked.
REQ-008 The block SHALL have port iVGA_HS/iVGA_VS/iVGA_SYNC_N/iVGA_BLANK_N  in  1 each  incoming sync (HS/VS low during sync; BLANK_N high in active area).
REQ-009 The block SHALL have port start  in  1  capture request, sampled each cycle.
REQ-010 The block SHALL have port mode  in  2  00 live, 01 replay, 10 live-threshold, 11 replay-threshold.
REQ-011 The block SHALL have port thresh  in  8  green threshold for mask modes.
REQ-012 The block SHALL have port oVGA_R/oVGA_G/oVGA_B  out  8 each  outgoing colour.
REQ-013 The block SHALL have port oVGA_HS/oVGA_VS/oVGA_SYNC_N/oVGA_BLANK_N  out  1 each  delayed sync.
REQ-014 The block SHALL have port busy  out  1  high whenever the capture FSM is not IDLE.
REQ-015 The block SHALL have port frame_valid  out  1  window memory holds one complete captured frame.
REQ-016 The block SHALL have port frame_cnt  out  8  completed captures, modulo 256.

Function
REQ-017 Coordinates: x (11 b) SHALL increment each cycle BLANK_N=1 and clear when BLANK_N=0; y (11 b) SHALL increment on each 1->0 BLANK_N edge and clear while VS=0.
REQ-018 Window SHALL be X0<=x<X0+WIN_W and Y0<=y<Y0+WIN_H with BLANK_N=1; memory depth WIN_W*WIN_H, 24 b {R,G,B}, address (y-Y0)*WIN_W+(x-X0).
REQ-019 FSM states SHALL be IDLE, ARM, SYNC, LOAD.
REQ-020 IDLE->ARM on start=1; ARM->SYNC when VS=0; SYNC->LOAD when VS=1; LOAD->IDLE when VS=0.
REQ-021 start SHALL be ignored when busy=1.
REQ-022 On SYNC->LOAD, frame_valid SHALL clear; on LOAD->IDLE, frame_valid SHALL set and frame_cnt SHALL increment (255 wraps to 0).
REQ-023 In LOAD, every in-window pixel SHALL be written with the current input colour; out-of-window pixels SHALL NOT be written.
REQ-024 Outputs SHALL be registered, with a latency of exactly 1 cycle for all colour and sync outputs.
REQ-025 Source pixel: in modes 01/11, in-window with frame_valid=1, use the stored pixel; in-window with frame_valid=0, use 0; otherwise use the live input.
REQ-026 Modes 10/11 SHALL output 8'hFF on all channels if source G>thresh, R<128 and B<128; otherwise 0.
REQ-027 With BLANK_N=0, colour outputs SHALL be 0 regardless of mode.
REQ-028 Simultaneous read and write of the same address SHALL return the old data (read-before-write).
REQ-029 mode and thresh SHALL take effect on the next pixel, with no frame alignment.

Reset
REQ-030 While reset=1, state SHALL be IDLE, busy=0, frame_valid=0, frame_cnt=0, all oVGA_*=0, x=y=0.
REQ-031 Reset mid-LOAD SHALL abort the capture with frame_valid=0; memory contents are not cleared.
REQ-032 A start asserted on the cycle reset releases SHALL be ignored; start is honoured from the following cycle.

Verification
REQ-033 Config WIN 4x4, X0=2, Y0=1, 10x10 active, input R=x, G=y, B=x+y. Scenario: start pulse, then mode 01 -> after the next VS low, frame_valid=1 and frame_cnt=1; window pixel (3,2) outputs {3,2,5} one cycle later; pixel (0,0) outputs live {0,0,0}.
REQ-034 Scenario: mode 01 with no capture since reset -> window outputs 0 and out-of-window is live.
REQ-035 Scenario: mode 10, thresh=4 -> pixel G=5, R=3, B=8 gives FF/FF/FF; pixel G=4 gives 0.
REQ-036 Scenario: reset asserted while in LOAD -> busy=0, frame_valid=0, frame_cnt unchanged at 0; a new start completes a capture normally.
REQ-037 Scenario: 256 back-to-back captures -> frame_cnt=0 and frame_valid=1; start pulses during busy do not add captures.
REQ-038 Scenario: all modes -> oVGA_HS/VS/BLANK_N equal inputs delayed 1 cycle, and colour is 0 whenever oVGA_BLANK_N=0.

Source files
------------

// File: rtl/vga_frame_grab_if.sv
// VGA stream bundle: incoming colour/sync and the delayed outgoing copy.
// master drives the incoming stream, slave is the frame grabber.
interface vga_frame_grab_if;
  logic [7:0] iVGA_R;
  logic [7:0] iVGA_G;
  logic [7:0] iVGA_B;
  logic       iVGA_HS;
  logic       iVGA_VS;
  logic       iVGA_SYNC_N;
  logic       iVGA_BLANK_N;
  logic [7:0] oVGA_R;
  logic [7:0] oVGA_G;
  logic [7:0] oVGA_B;
  logic       oVGA_HS;
  logic       oVGA_VS;
  logic       oVGA_SYNC_N;
  logic       oVGA_BLANK_N;

  modport master (
    output iVGA_R, iVGA_G, iVGA_B,
    output iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N,
    input  oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N
  );

  modport slave (
    input  iVGA_R, iVGA_G, iVGA_B,
    input  iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N,
    output oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N
  );
endinterface

// File: rtl/vga_frame_grab.sv
// Captures one windowed frame of a VGA stream and replays it,
// optionally as a green-threshold mask, with one cycle of latency.
module vga_frame_grab #(
  parameter int WIN_W = 100,
  parameter int WIN_H = 100,
  parameter int X0    = 0,
  parameter int Y0    = 0
) (
  input  logic            VGA_CLK,
  input  logic            reset,
  vga_frame_grab_if.slave vga,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [7:0]      thresh,
  output logic            busy,
  output logic            frame_valid,
  output logic [7:0]      frame_cnt
);

  localparam int DEPTH = WIN_W * WIN_H;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] XLO = 11'(X0);
  localparam logic [10:0] YLO = 11'(Y0);
  localparam logic [10:0] WW  = 11'(WIN_W);
  localparam logic [10:0] WH  = 11'(WIN_H);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SYNC,
    LOAD
  } state_t;

  state_t      r_state;
  logic        r_rst_d;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_blank_d;
  logic [23:0] r_mem [DEPTH];

  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic          w_in_win;
  logic [AW-1:0] w_addr;
  logic [23:0]   w_live;
  logic [23:0]   w_rd;
  logic [23:0]   w_src;
  logic [23:0]   w_pix;
  logic          w_vs;
  logic          w_bn;

  assign w_vs = vga.iVGA_VS;
  assign w_bn = vga.iVGA_BLANK_N;
  assign w_live = {vga.iVGA_R, vga.iVGA_G, vga.iVGA_B};

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_blank_d <= 1'b0;
    end else begin
      r_blank_d <= w_bn;
      r_x       <= w_bn ? r_x + 11'd1 : '0;
      if (!w_vs)
        r_y <= '0;
      else if (r_blank_d && !w_bn)
        r_y <= r_y + 11'd1;
    end
  end

  // Offsets wrap to large values left of / above the window.
  assign w_dx = r_x - XLO;
  assign w_dy = r_y - YLO;
  assign w_in_win = w_bn && (w_dx < WW) && (w_dy < WH);
  assign w_addr = AW'(22'(w_dy) * 22'(WIN_W) + 22'(w_dx));

  // Asynchronous read gives old data on a same-address write.
  assign w_rd = r_mem[w_addr];

  always_ff @(posedge VGA_CLK) begin
    if (!reset && r_state == LOAD && w_in_win)
      r_mem[w_addr] <= w_live;
  end

  always_comb begin
    w_src = w_live;
    if (mode[0] && w_in_win)
      w_src = frame_valid ? w_rd : '0;
    w_pix = w_src;
    if (mode[1])
      w_pix = (w_src[15:8] > thresh && !w_src[23] && !w_src[7])
            ? 24'hFFFFFF : 24'h0;
    if (!w_bn)
      w_pix = '0;
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      vga.oVGA_R       <= '0;
      vga.oVGA_G       <= '0;
      vga.oVGA_B       <= '0;
      vga.oVGA_HS      <= 1'b0;
      vga.oVGA_VS      <= 1'b0;
      vga.oVGA_SYNC_N  <= 1'b0;
      vga.oVGA_BLANK_N <= 1'b0;
    end else begin
      vga.oVGA_R       <= w_pix[23:16];
      vga.oVGA_G       <= w_pix[15:8];
      vga.oVGA_B       <= w_pix[7:0];
      vga.oVGA_HS      <= vga.iVGA_HS;
      vga.oVGA_VS      <= w_vs;
      vga.oVGA_SYNC_N  <= vga.iVGA_SYNC_N;
      vga.oVGA_BLANK_N <= w_bn;
    end
  end

  // r_rst_d masks a start seen on the first cycle out of reset.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rst_d     <= 1'b1;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      r_rst_d <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && !r_rst_d) begin
            r_state <= ARM;
            busy    <= 1'b1;
          end
        end
        ARM: begin
          if (!w_vs)
            r_state <= SYNC;
        end
        SYNC: begin
          if (w_vs) begin
            r_state     <= LOAD;
            frame_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (!w_vs) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_grab.sv
// Bench for vga_frame_grab: 4x4 window at (2,1) in a 10x10 active
// raster, compared each cycle against a frame-level reference model.
module tb_vga_frame_grab;

  localparam int HT = 14;
  localparam int VT = 12;
  localparam int ACT = 10;

  logic       VGA_CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       busy;
  logic       frame_valid;
  logic [7:0] frame_cnt;

  vga_frame_grab_if vga();

  vga_frame_grab #(
    .WIN_W(4),
    .WIN_H(4),
    .X0(2),
    .Y0(1)
  ) dut (
    .VGA_CLK(VGA_CLK),
    .reset(reset),
    .vga(vga),
    .start(start),
    .mode(mode),
    .thresh(thresh),
    .busy(busy),
    .frame_valid(frame_valid),
    .frame_cnt(frame_cnt)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  int hc = 0;
  int vc = 0;
  int lx = 0;
  int ly = 0;
  bit rnd_pix = 1'b0;

  // Reference: captured picture, capture phase, flags.
  // phase 0 idle, 1 waiting VS low, 2 waiting VS high, 3 loading
  logic [23:0] img [4][4];
  int m_phase = 0;
  bit m_valid = 1'b0;
  int m_cnt = 0;
  bit m_just_rst = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] out_col();
    return {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B};
  endfunction

  task automatic cycle();
    logic act, hs, vs, sn, inw;
    logic [23:0] col, src, pix;
    logic [30:0] exp_out;
    act = (hc < ACT) && (vc < ACT);
    hs = !(hc == 11 || hc == 12);
    vs = (vc != 11);
    sn = (hc % 3) != 0;
    col = '0;
    if (act)
      col = rnd_pix ? 24'($urandom)
                    : {8'(hc), 8'(vc), 8'(hc + vc)};
    vga.iVGA_R = col[23:16];
    vga.iVGA_G = col[15:8];
    vga.iVGA_B = col[7:0];
    vga.iVGA_HS = hs;
    vga.iVGA_VS = vs;
    vga.iVGA_SYNC_N = sn;
    vga.iVGA_BLANK_N = act;
    inw = act && hc >= 2 && hc < 6 && vc >= 1 && vc < 5;

    src = col;
    if (mode[0] && inw)
      src = m_valid ? img[vc-1][hc-2] : 24'h0;
    pix = src;
    if (mode[1])
      pix = (src[15:8] > thresh && src[23:16] < 128 && src[7:0] < 128)
          ? 24'hFFFFFF : 24'h0;
    if (!act)
      pix = '0;
    exp_out = reset ? 31'h0 : {pix, hs, vs, sn, act};

    if (reset) begin
      m_phase = 0;
      m_valid = 1'b0;
      m_cnt = 0;
      m_just_rst = 1'b1;
    end else begin
      if (m_phase == 0) begin
        if (start && !m_just_rst) m_phase = 1;
      end else if (m_phase == 1) begin
        if (!vs) m_phase = 2;
      end else if (m_phase == 2) begin
        if (vs) begin
          m_phase = 3;
          m_valid = 1'b0;
        end
      end else begin
        if (inw) img[vc-1][hc-2] = col;
        if (!vs) begin
          m_phase = 0;
          m_valid = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
        end
      end
      m_just_rst = 1'b0;
    end
    lx = hc;
    ly = vc;

    @(posedge VGA_CLK);
    #1;
    check("pix", {out_col(), vga.oVGA_HS, vga.oVGA_VS,
                  vga.oVGA_SYNC_N, vga.oVGA_BLANK_N}, exp_out);
    check("ctl", {busy, frame_valid, frame_cnt},
          {m_phase != 0, m_valid, 8'(m_cnt)});

    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc + 1) % VT;
    end
  endtask

  task automatic to_frame_start();
    do cycle(); while (!(hc == 0 && vc == 0));
  endtask

  task automatic run_frames(int n);
    repeat (n * HT * VT) cycle();
  endtask

  task automatic run_to(int x, int y);
    bit found = 1'b0;
    for (int i = 0; i < HT * VT && !found; i++) begin
      cycle();
      found = (lx == x && ly == y);
    end
    if (!found) check("run_to", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    thresh = 8'd0;
    repeat (3) cycle();
    to_frame_start();
    check("rst_ctl", {busy, frame_valid, frame_cnt}, 64'd0);
    check("rst_out", {out_col(), vga.oVGA_HS, vga.oVGA_VS,
                      vga.oVGA_SYNC_N, vga.oVGA_BLANK_N}, 64'd0);

    // start on the release cycle must be ignored
    reset = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("start_ign", busy, 64'd0);

    // replay before any capture
    mode = 2'b01;
    run_to(3, 2);
    check("nocap_win", out_col(), 64'h0);
    run_to(7, 7);
    check("nocap_live", out_col(), 64'h07070E);

    // one capture, then replay
    to_frame_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("cap_busy", busy, 64'd1);
    to_frame_start();
    run_frames(1);
    check("cap_valid", frame_valid, 64'd1);
    check("cap_cnt", frame_cnt, 64'd1);
    run_to(0, 0);
    check("replay_00", out_col(), 64'h0);
    run_to(3, 2);
    check("replay_32", out_col(), 64'h030205);

    // live threshold
    mode = 2'b10;
    thresh = 8'd4;
    run_to(3, 4);
    check("thr_g4", out_col(), 64'h0);
    run_to(3, 5);
    check("thr_g5", out_col(), 64'hFFFFFF);

    // reset in the middle of a load
    to_frame_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3 * HT * VT && !(m_phase == 3 && vc == 3); i++)
      cycle();
    check("in_load", busy, 64'd1);
    reset = 1'b1;
    cycle();
    to_frame_start();
    reset = 1'b0;
    check("abort_ctl", {busy, frame_valid, frame_cnt}, 64'd0);
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    to_frame_start();
    run_frames(1);
    check("recap_valid", frame_valid, 64'd1);
    check("recap_cnt", frame_cnt, 64'd1);

    // random pixels, modes, thresholds and start pulses
    rnd_pix = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode = 2'($urandom);
        thresh = 8'($urandom);
      end
      start = ($urandom_range(0, 99) < 3);
      cycle();
    end
    start = 1'b0;

    // 256 captures with start held high throughout
    reset = 1'b1;
    cycle();
    to_frame_start();
    reset = 1'b0;
    start = 1'b1;
    begin
      int n = 0;
      int prev;
      for (int i = 0; i < 260 * HT * VT && n < 256; i++) begin
        prev = m_cnt;
        cycle();
        if (m_cnt != prev) n++;
      end
      check("cap256_done", 64'(n), 64'd256);
    end
    start = 1'b0;
    check("cap256_cnt", frame_cnt, 64'd0);
    check("cap256_valid", frame_valid, 64'd1);
    run_frames(1);
    check("cap256_idle", {busy, frame_cnt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
